// File: rtl/int_controller.sv
// int_controller: interrupt source side of the CPU interrupt interface.
// Synchronises up to N_IRQ request lines, latches their rising edges as
// pending, masks them, and presents the lowest-index candidate to the cpu.
// Exactly one interrupt can be in service at a time. It is released by int_ret.
//
// Handshake: there is no ack. The cpu takes the interrupt on any posedge
// where int_req=1. On that same edge the controller moves to in-service,
// records the id, and clears its pending bit. As a result int_req is high
// for exactly one cycle per acceptance.
module int_controller #(
    parameter int         N_IRQ      = 4,
    parameter logic [7:0] BASE_ADDR  = 8'hF0,
    parameter logic [7:0] VEC_BASE   = 8'hE0,
    parameter logic [7:0] VEC_STRIDE = 8'h04
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [N_IRQ-1:0] irq,
    input  logic [7:0]       bus_addr,
    input  logic             bus_w_en,
    input  logic [7:0]       bus_w_data,
    output logic [7:0]       bus_r_data,
    input  logic             int_ret,
    output logic             int_req,
    output logic [7:0]       int_en,
    output logic [7:0]       int_vec
);

    // Register offsets inside the 4-address window.
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_MASK   = 2'd1;
    localparam logic [1:0] OFF_PEND   = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    localparam logic [N_IRQ-1:0] IRQ_ONE = N_IRQ'(1);

    // Service state: in_service is the BUSY state. It is readable in STATUS[7].
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } svc_state_t;

    svc_state_t         state_q, state_d;
    logic [N_IRQ-1:0]   irq_s1_q, irq_s2_q, irq_s3_q;
    logic               gie_q, gie_d;
    logic [N_IRQ-1:0]   mask_q, mask_d;
    logic [N_IRQ-1:0]   pend_q, pend_d;
    logic [2:0]         active_id_q, active_id_d;

    logic [7:0]         reg_off;
    logic               in_window;
    logic               wr_ctrl, wr_mask, wr_pend;
    logic [N_IRQ-1:0]   rise;
    logic [N_IRQ-1:0]   cand;
    logic [N_IRQ-1:0]   sel_onehot;
    logic               any_cand;
    logic [2:0]         sel_id;
    logic               in_service;
    logic               accept;
    logic [7:0]         vec_id;
    logic [7:0]         mask_ext, pend_ext;
    logic               unused_w_data;

    // Only the low N_IRQ data bits matter to MASK/PEND. The rest are dropped.
    assign unused_w_data = ^bus_w_data;

    // Address decode. The subtraction wraps, so any address below BASE_ADDR
    // lands far outside the 0..3 window.
    assign reg_off   = bus_addr - BASE_ADDR;
    assign in_window = (reg_off < 8'd4);
    assign wr_ctrl   = bus_w_en & in_window & (reg_off[1:0] == OFF_CTRL);
    assign wr_mask   = bus_w_en & in_window & (reg_off[1:0] == OFF_MASK);
    assign wr_pend   = bus_w_en & in_window & (reg_off[1:0] == OFF_PEND);

    // A rising edge is seen one stage after the second synchroniser flop.
    assign rise = irq_s2_q & ~irq_s3_q;

    assign cand       = pend_q & mask_q;
    assign any_cand   = |cand;
    // Isolate the lowest set candidate bit.
    assign sel_onehot = cand & ~(cand - IRQ_ONE);

    // Encode the lowest-index candidate. The downward scan lets the lowest index win.
    always_comb begin
        sel_id = 3'd0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel_id = 3'(i);
            end
        end
    end

    assign in_service = (state_q == ST_BUSY);
    assign int_req    = gie_q & ~in_service & any_cand;
    assign accept     = int_req;
    assign int_en     = {7'd0, gie_q};

    // With no candidate, the vector falls back to the last serviced source.
    assign vec_id  = {5'd0, (any_cand ? sel_id : active_id_q)};
    assign int_vec = VEC_BASE + vec_id * VEC_STRIDE;

    // Service state machine: next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)  state_d = ST_BUSY;
            ST_BUSY: if (int_ret) state_d = ST_IDLE;
            default:              state_d = ST_IDLE;
        endcase
    end

    // Active id follows the accepted source and holds until the next acceptance.
    always_comb begin
        active_id_d = active_id_q;
        if (accept) begin
            active_id_d = sel_id;
        end
    end

    // Control and mask registers written from the bus.
    always_comb begin
        gie_d  = gie_q;
        mask_d = mask_q;
        if (wr_ctrl) begin
            gie_d = bus_w_data[0];
        end
        if (wr_mask) begin
            mask_d = bus_w_data[N_IRQ-1:0];
        end
    end

    // Pending update. A new rise is applied last, so it beats both the W1C
    // clear and the acceptance clear on the same bit.
    always_comb begin
        pend_d = pend_q;
        if (wr_pend) begin
            pend_d = pend_d & ~bus_w_data[N_IRQ-1:0];
        end
        if (accept) begin
            pend_d = pend_d & ~sel_onehot;
        end
        pend_d = pend_d | rise;
    end

    // Zero-extended register views for the read mux.
    always_comb begin
        mask_ext               = 8'd0;
        pend_ext               = 8'd0;
        mask_ext[N_IRQ-1:0]    = mask_q;
        pend_ext[N_IRQ-1:0]    = pend_q;
    end

    // Combinational read data. It reads 0 outside the window.
    always_comb begin
        bus_r_data = 8'd0;
        if (in_window) begin
            case (reg_off[1:0])
                OFF_CTRL:   bus_r_data = {7'd0, gie_q};
                OFF_MASK:   bus_r_data = mask_ext;
                OFF_PEND:   bus_r_data = pend_ext;
                OFF_STATUS: bus_r_data = {in_service, 4'd0, active_id_q};
                default:    bus_r_data = 8'd0;
            endcase
        end
    end

    // Three-flop input synchroniser and edge history.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            irq_s1_q <= '0;
            irq_s2_q <= '0;
            irq_s3_q <= '0;
        end else begin
            irq_s1_q <= irq;
            irq_s2_q <= irq_s1_q;
            irq_s3_q <= irq_s2_q;
        end
    end

    // Architectural state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            gie_q       <= 1'b0;
            mask_q      <= '0;
            pend_q      <= '0;
            active_id_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            gie_q       <= gie_d;
            mask_q      <= mask_d;
            pend_q      <= pend_d;
            active_id_q <= active_id_d;
        end
    end

endmodule

// File: tb/tb_int_controller.sv
// tb_int_controller: directed scenarios plus randomized traffic for
// int_controller. The reference model works from the register-level rules,
// and it keeps the irq history as a plain list of per-edge samples.
module tb_int_controller;

  localparam int         N_IRQ   = 4;
  localparam logic [7:0] BASE    = 8'hF0;
  localparam logic [7:0] VBASE   = 8'hE0;
  localparam logic [7:0] VSTRIDE = 8'h04;
  localparam int         ALLBITS = (1 << N_IRQ) - 1;

  // ---------------- clock / reset ----------------
  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [N_IRQ-1:0] irq = '0;
  logic [7:0]       bus_addr = 8'h00;
  logic             bus_w_en = 1'b0;
  logic [7:0]       bus_w_data = 8'h00;
  logic [7:0]       bus_r_data;
  logic             int_ret = 1'b0;
  logic             int_req;
  logic [7:0]       int_en;
  logic [7:0]       int_vec;

  always #5 clock = ~clock;

  int_controller #(
    .N_IRQ(N_IRQ), .BASE_ADDR(BASE), .VEC_BASE(VBASE), .VEC_STRIDE(VSTRIDE)
  ) dut (
    .clock(clock), .reset_n(reset_n), .irq(irq),
    .bus_addr(bus_addr), .bus_w_en(bus_w_en), .bus_w_data(bus_w_data),
    .bus_r_data(bus_r_data), .int_ret(int_ret), .int_req(int_req),
    .int_en(int_en), .int_vec(int_vec)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_gie, m_mask, m_pend, m_insvc, m_act;
  int hist_q[$];  // irq samples, one per edge, newest at the back

  function automatic int lowest(input int v);
    for (int i = 0; i < N_IRQ; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_gie = 0; m_mask = 0; m_pend = 0; m_insvc = 0; m_act = 0;
    hist_q = {};
    repeat (3) hist_q.push_back(0);
  endtask

  // One clock edge with the given inputs.
  task automatic model_step(input int irq_v, input int addr, input int wen,
                            input int wdata, input int ret);
    int rise, cand, sel, off, np;
    bit req;
    // An edge sampled two edges ago that was low the edge before sets pending now.
    rise = hist_q[$-1] & ~hist_q[$-2] & ALLBITS;
    cand = m_pend & m_mask;
    req  = (m_gie != 0) && (m_insvc == 0) && (cand != 0);
    sel  = lowest(cand);
    np   = m_pend;
    off  = (addr - BASE) & 255;
    if (wen != 0 && off < 4) begin
      case (off)
        0: m_gie  = wdata & 1;
        1: m_mask = wdata & ALLBITS;
        2: np     = np & ~wdata;
        default: ;
      endcase
    end
    if (req) begin
      np      = np & ~(1 << sel);
      m_insvc = 1;
      m_act   = sel;
    end else if (ret != 0 && m_insvc != 0) begin
      m_insvc = 0;
    end
    m_pend = (np | rise) & ALLBITS;
    hist_q.push_back(irq_v & ALLBITS);
    if (hist_q.size() > 4) void'(hist_q.pop_front());
  endtask

  task automatic model_expect(input int addr);
    int cand, off, id, rd;
    bit req;
    cand = m_pend & m_mask;
    req  = (m_gie != 0) && (m_insvc == 0) && (cand != 0);
    id   = (cand != 0) ? lowest(cand) : m_act;
    off  = (addr - BASE) & 255;
    rd   = 0;
    if (off == 0) rd = m_gie;
    if (off == 1) rd = m_mask;
    if (off == 2) rd = m_pend;
    if (off == 3) rd = (m_insvc << 7) | m_act;
    exp_q.push_back(8'(req));
    exp_q.push_back(8'(m_gie));
    exp_q.push_back(8'((VBASE + id * VSTRIDE) & 255));
    exp_q.push_back(8'(rd));
  endtask

  task automatic compare_outputs();
    model_expect(bus_addr);
    check("int_req", {7'd0, int_req}, exp_q.pop_front());
    check("int_en", int_en, exp_q.pop_front());
    check("int_vec", int_vec, exp_q.pop_front());
    check("bus_r_data", bus_r_data, exp_q.pop_front());
  endtask

  // ---------------- driver ----------------
  task automatic do_cycle(input logic [N_IRQ-1:0] irq_v, input logic [7:0] addr,
                          input logic wen, input logic [7:0] wdata, input logic ret);
    irq = irq_v; bus_addr = addr; bus_w_en = wen; bus_w_data = wdata; int_ret = ret;
    @(negedge clock);
    compare_outputs();
    @(posedge clock);
    model_step(irq_v, addr, wen, wdata, ret);
    #1;
  endtask

  task automatic idle(input logic [N_IRQ-1:0] irq_v, input logic [7:0] addr);
    do_cycle(irq_v, addr, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic ret_cycle(input logic [N_IRQ-1:0] irq_v);
    do_cycle(irq_v, 8'hF3, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic wr(input logic [N_IRQ-1:0] irq_v, input logic [7:0] addr, input logic [7:0] d);
    do_cycle(irq_v, addr, 1'b1, d, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r_irq;
    logic [7:0] a, d;
    logic w, rt;

    // Reset state
    bus_addr = 8'hF3;
    repeat (2) @(negedge clock);
    check("rst_int_req", {7'd0, int_req}, 8'h00);
    check("rst_int_en", int_en, 8'h00);
    check("rst_int_vec", int_vec, 8'hE0);
    check("rst_status", bus_r_data, 8'h00);
    reset_n = 1'b1;
    @(posedge clock); #1;
    model_reset();

    // Single source, full path latency
    wr('0, 8'hF1, 8'h0F);
    wr('0, 8'hF0, 8'h01);
    idle(4'h4, 8'hF3);
    idle(4'h0, 8'hF3);
    idle(4'h0, 8'hF3);
    check("t1_req", {7'd0, int_req}, 8'h01);
    check("t1_vec", int_vec, 8'hE8);
    idle(4'h0, 8'hF3);
    check("t1_req_drop", {7'd0, int_req}, 8'h00);
    check("t1_status", bus_r_data, 8'h82);
    idle(4'h0, 8'hF2);
    check("t1_pend", bus_r_data, 8'h00);
    ret_cycle(4'h0);

    // Two simultaneous sources: priority then the second after ret
    idle(4'hA, 8'hF3);
    idle(4'hA, 8'hF3);
    idle(4'hA, 8'hF3);
    check("t2_req", {7'd0, int_req}, 8'h01);
    check("t2_vec1", int_vec, 8'hE4);
    idle(4'hA, 8'hF3);
    check("t2_busy_req", {7'd0, int_req}, 8'h00);
    ret_cycle(4'hA);
    check("t2_req2", {7'd0, int_req}, 8'h01);
    check("t2_vec2", int_vec, 8'hEC);
    idle(4'hA, 8'hF3);
    check("t2_status", bus_r_data, 8'h83);
    ret_cycle(4'hA);

    // Masked source stays pending, unmasking raises the request
    wr(4'hA, 8'hF1, 8'h0E);
    idle(4'h1, 8'hF2);
    idle(4'h1, 8'hF2);
    idle(4'h1, 8'hF2);
    check("t3_masked_req", {7'd0, int_req}, 8'h00);
    check("t3_pend", bus_r_data, 8'h01);
    wr(4'h1, 8'hF1, 8'h0F);
    check("t3_unmask_req", {7'd0, int_req}, 8'h01);
    idle(4'h1, 8'hF3);
    ret_cycle(4'h1);

    // Request arriving while in service waits for ret
    idle(4'h4, 8'hF3);
    idle(4'h4, 8'hF3);
    idle(4'h4, 8'hF3);
    idle(4'h4, 8'hF3);
    idle(4'h6, 8'hF3);
    idle(4'h6, 8'hF3);
    idle(4'h6, 8'hF3);
    check("t4_nested_req", {7'd0, int_req}, 8'h00);
    ret_cycle(4'h6);
    check("t4_after_ret_req", {7'd0, int_req}, 8'h01);
    check("t4_after_ret_vec", int_vec, 8'hE4);
    idle(4'h6, 8'hF3);
    ret_cycle(4'h6);

    // A rise on the same edge as a W1C of that bit wins
    wr(4'h6, 8'hF1, 8'h00);
    idle(4'h0, 8'hF2);
    idle(4'h0, 8'hF2);
    wr(4'h0, 8'hF2, 8'hFF);
    idle(4'h4, 8'hF2);
    idle(4'h4, 8'hF2);
    wr(4'h4, 8'hF2, 8'h04);
    check("t5_pend_kept", bus_r_data, 8'h04);

    // Asynchronous reset while in service
    wr(4'h4, 8'hF1, 8'h0F);
    idle(4'h4, 8'hF3);
    check("t6_status_busy", bus_r_data, 8'h82);
    reset_n = 1'b0;
    #2;
    check("t6_status_rst", bus_r_data, 8'h00);
    check("t6_req_rst", {7'd0, int_req}, 8'h00);
    check("t6_en_rst", int_en, 8'h00);
    model_reset();
    irq = '0;
    #1 reset_n = 1'b1;
    idle(4'h0, 8'hF3);
    wr('0, 8'hF1, 8'h0F);
    wr('0, 8'hF0, 8'h01);

    // Randomized traffic against the model
    r_irq = 0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) r_irq = r_irq ^ (1 << $urandom_range(0, N_IRQ - 1));
      a  = 8'($urandom_range(8'hEE, 8'hF4));
      w  = ($urandom_range(0, 5) == 0);
      d  = 8'($urandom_range(0, 255));
      if (a == 8'hF0) d = ($urandom_range(0, 3) != 0) ? 8'h01 : 8'h00;
      if (a == 8'hF1 && $urandom_range(0, 2) != 0) d = 8'h0F;
      rt = (m_insvc != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      do_cycle(r_irq[N_IRQ-1:0], a, w, d, rt);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
